// File: rtl/mem_arbiter.sv
// Arbiter sharing one line-wide memory port between icache refill and dcache
// refill/writeback; owner holds the port until memory completes.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int PHY_LEN  = 20,
  parameter int LINE_LEN = 128,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ic_ldp,
  input  logic [PHY_LEN-1:0]  ic_addr,
  output logic                ic_ldr,
  output logic [LINE_LEN-1:0] ic_ldData,
  input  logic                dc_ldp,
  input  logic                dc_srp,
  input  logic [PHY_LEN-1:0]  dc_addr,
  input  logic [LINE_LEN-1:0] dc_stData,
  output logic                dc_ldr,
  output logic                dc_srr,
  output logic [LINE_LEN-1:0] dc_ldData,
  output logic                mem_ldp,
  output logic                mem_srp,
  output logic [PHY_LEN-1:0]  mem_addr,
  output logic [LINE_LEN-1:0] mem_stData,
  input  logic                mem_ldr,
  input  logic                mem_srr,
  input  logic [LINE_LEN-1:0] mem_ldData,
  output logic                busy,
  output logic [CNT_W-1:0]    wait_cnt
);

  typedef enum logic [1:0] {IDLE, I_LD, D_LD, D_ST} state_t;

  localparam logic [PHY_LEN-1:0] LINE_MASK = PHY_LEN'('hF);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  state_t             r_state, w_next;
  logic               r_last_dc;  // 1 when the dcache was the most recent owner
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               w_dc_req;
  logic               w_wait;
  logic [PHY_LEN-1:0] w_addr_sel;

  always_comb begin
    w_dc_req = dc_ldp | dc_srp;
    w_next   = r_state;
    case (r_state)
      // on a tie the dcache wins unless it owned the port last
      IDLE: if (w_dc_req && (!ic_ldp || !r_last_dc)) w_next = dc_srp ? D_ST : D_LD;
            else if (ic_ldp)                         w_next = I_LD;
      I_LD: if (mem_ldr) w_next = IDLE;
      D_LD: if (mem_ldr) w_next = IDLE;
      D_ST: if (mem_srr) w_next = D_LD;  // eviction locked to its refill
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_ldp    = 1'b0;
    mem_srp    = 1'b0;
    w_addr_sel = '0;
    mem_stData = '0;
    ic_ldr     = 1'b0;
    dc_ldr     = 1'b0;
    dc_srr     = 1'b0;
    case (r_state)
      I_LD: begin mem_ldp = 1'b1; w_addr_sel = ic_addr; ic_ldr = mem_ldr; end
      D_LD: begin mem_ldp = 1'b1; w_addr_sel = dc_addr; dc_ldr = mem_ldr; end
      D_ST: begin
        mem_srp    = 1'b1;
        w_addr_sel = dc_addr;
        mem_stData = dc_stData;
        dc_srr     = mem_srr;
      end
      default: ;
    endcase
    mem_addr  = w_addr_sel & ~LINE_MASK;
    ic_ldData = mem_ldData;
    dc_ldData = mem_ldData;
    busy      = (r_state != IDLE);
    w_wait    = (ic_ldp && r_state != I_LD) ||
                (w_dc_req && r_state != D_LD && r_state != D_ST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_dc  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == I_LD)      r_last_dc <= 1'b0;
      else if (r_state == IDLE && w_next != IDLE) r_last_dc <= 1'b1;
      if (w_wait && !(&r_wait_cnt)) r_wait_cnt <= r_wait_cnt + CNT_ONE;
    end
  end

  assign wait_cnt = r_wait_cnt;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single line-wide memory port between the instruction cache refill path and the data cache refill/writeback path. Requests are registered, so grant is one cycle behind the request. A granted requester owns the port until memory completes the transfer. A dirty-line eviction is locked to its following refill. Responses are routed only to the owner, and a saturating counter records cycles lost to contention.

## Interface
Parameters:
- PHY_LEN, 20: physical address width.
- LINE_LEN, 128: cache line width in bits, shared by both caches.
- CNT_W, 16: width of the contention counter.

Ports:
- clk  in  1: clock.
- rst  in  1: synchronous, active-high reset.
- ic_ldp  in  1: icache line-load request.
- ic_addr  in  PHY_LEN: icache line address; held stable while ic_ldp is high.
- ic_ldr  out  1: icache load ready, one-cycle pulse.
- ic_ldData  out  LINE_LEN: refill line to icache.
- dc_ldp  in  1: dcache line-load request.
- dc_srp  in  1: dcache line-store (writeback) request.
- dc_addr  in  PHY_LEN: dcache line address; held stable while a request is high.
- dc_stData  in  LINE_LEN: writeback line.
- dc_ldr  out  1: dcache load ready, one-cycle pulse.
- dc_srr  out  1: dcache store ready, one-cycle pulse.
- dc_ldData  out  LINE_LEN: refill line to dcache.
- mem_ldp  out  1: load request to memory.
- mem_srp  out  1: store request to memory.
- mem_addr  out  PHY_LEN: address to memory; bits [3:0] forced to 0.
- mem_stData  out  LINE_LEN: store data to memory.
- mem_ldr  in  1: memory load complete; mem_ldData valid this cycle.
- mem_srr  in  1: memory store complete.
- mem_ldData  in  LINE_LEN: loaded line.
- busy  out  1: high in any state other than IDLE.
- wait_cnt  out  CNT_W: saturating count of cycles in which a requester is pending but not owner.

## Operation
States:
- IDLE: no owner.
- I_LD: icache owns the port for a load.
- D_LD: dcache owns the port for a load.
- D_ST: dcache owns the port for a writeback.

IDLE arbitration, evaluated on the registered state:
- dcache request = dc_ldp | dc_srp. If dc_srp is high, the target is D_ST, even when dc_ldp is also high; otherwise D_LD.
- Only icache requests: go to I_LD.
- Only dcache requests: go to D_ST or D_LD as above.
- Both request: round-robin on last_owner (1 bit). Grant the requester that was not last_owner.
- last_owner updates on entry to I_LD or D_LD/D_ST.

Transfers:
- I_LD: mem_ldp=1, mem_addr=ic_addr. On mem_ldr, pulse ic_ldr and go to IDLE.
- D_LD: mem_ldp=1, mem_addr=dc_addr. On mem_ldr, pulse dc_ldr and go to IDLE.
- D_ST: mem_srp=1, mem_addr=dc_addr, mem_stData=dc_stData. On mem_srr, pulse dc_srr and go directly to D_LD (eviction lock), without re-arbitration and without an icache window. D_LD then issues the refill using the dcache's updated dc_addr.

Routing and idle values:
- mem_ldr is forwarded only to the owner's ldr.
- ic_ldData and dc_ldData both carry mem_ldData unconditionally; the consumer qualifies on its ldr.
- mem_ldr in D_ST and mem_srr in any load state are ignored.
- In IDLE: mem_ldp=0, mem_srp=0, mem_addr=0, mem_stData=0.

wait_cnt:
- Increments by 1 per cycle while (ic_ldp & owner≠icache) or (dc request & owner≠dcache).
- Counts at most 1 per cycle.
- Saturates at all-ones.
- Includes the cycle a request spends in IDLE before grant.

## Timing
Reset (rst high at a clk edge):
- state=IDLE, last_owner=icache (so the dcache wins the first tie), wait_cnt=0.
- Outputs the following cycle: mem_ldp=0, mem_srp=0, mem_addr=0, mem_stData=0, ic_ldr=0, dc_ldr=0, dc_srr=0, busy=0.
- Reset mid-transfer abandons the transfer. No ready pulse is emitted; a memory response arriving afterward is ignored in IDLE.

Latency:
- Request seen in IDLE at cycle t: mem_ldp/mem_srp is high from cycle t+1.
- Memory completes at cycle n: the requester's ready pulse appears in the same cycle n (combinational).
- State is IDLE at n+1. A new request can be granted with memory request high at n+2.
- Minimum turnaround with 1-cycle memory: 3 cycles per transfer.

Handshake and output paths:
- Requesters hold their address and data until their ready pulse.
- Requests deasserted before grant are dropped; no stale grant is issued.
- mem_* outputs are muxed from registered state only and never depend combinationally on the *_ldp/*_srp inputs.
- ready outputs are combinational from mem_ldr/mem_srr and state.

## Test plan
- **Reset:** hold rst 2 cycles with ic_ldp=1 → all outputs 0 and busy=0 during reset. The cycle after release: state=I_LD, mem_ldp=1, mem_addr=ic_addr.
- **Single icache load:** ic_ldp=1, ic_addr=0x01230, memory ldr after 4 cycles with ldData=0xDEADBEEF… → mem_addr=0x01230, ic_ldr pulses once, dc_ldr stays 0, and mem_ldp returns to 0 the next cycle.
- **Eviction lock:** dc_srp=dc_ldp=1, dc_addr=0x0AB00; icache requests meanwhile → D_ST then D_LD with no I_LD in between. The icache is granted only after dc_ldr. wait_cnt equals the number of cycles the icache was pending.
- **Tie fairness:** both request continuously after reset with 1-cycle memory → grant order D, I, D, I. Each transfer takes 3 cycles.
- **Reset mid-load:** rst asserted in D_LD, then mem_ldr arrives → dc_ldr stays 0 and state=IDLE.
- **Saturation:** CNT_W=4, hold contention 20 cycles → wait_cnt stops at 15.
